// File: rtl/truth_table_sweep.sv
// Exhaustive stimulus/response sweep around a small combinational block.
// Drives vectors 0..N-1, samples one response bit per vector, grades vs expected.
module truth_table_sweep #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2**WIDTH-1:0]  i_expected,
  input  logic                 i_resp,
  output logic [WIDTH-1:0]     o_stim,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2**WIDTH-1:0]  o_table,
  output logic                 o_pass,
  output logic [WIDTH:0]       o_err_count,
  output logic [WIDTH-1:0]     o_first_fail
);

  localparam int N  = 2**WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE-1);
  localparam logic [WIDTH-1:0] VEC_LAST = WIDTH'(N-1);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_stim;
  logic [N-1:0]       r_exp_q;
  logic [N-1:0]       r_table;
  logic [WIDTH:0]     r_err;
  logic [WIDTH-1:0]   r_ff;
  logic               r_pass;
  logic               r_done;

  logic               w_accept;
  logic               w_sample;
  logic               w_last;
  logic               w_miss;
  logic [WIDTH:0]     w_err_nxt;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_sample  = (r_state == S_SWEEP) && (r_cnt == CNT_LAST);
  assign w_last    = (r_stim == VEC_LAST);
  assign w_miss    = (i_resp != r_exp_q[r_stim]);
  assign w_err_nxt = r_err + (WIDTH+1)'(w_miss);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_sample && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_SWEEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_stim  <= '0;
      r_exp_q <= '0;
      r_table <= '0;
      r_err   <= '0;
      r_ff    <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_exp_q <= i_expected;
        r_table <= '0;
        r_err   <= '0;
        r_ff    <= '0;
        r_pass  <= 1'b0;
        r_stim  <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_SWEEP) begin
        if (!w_sample) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_table[r_stim] <= i_resp;
          r_cnt           <= '0;
          r_err           <= w_err_nxt;
          // only the first mismatch of the sweep records its index
          if (w_miss && (r_err == '0)) r_ff <= r_stim;
          if (!w_last) begin
            r_stim <= r_stim + WIDTH'(1);
          end else begin
            r_stim <= '0;
            r_done <= 1'b1;
            r_pass <= (w_err_nxt == '0);
          end
        end
      end
    end
  end

  assign o_stim       = r_stim;
  assign o_done       = r_done;
  assign o_table      = r_table;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_first_fail = r_ff;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: majority DUT at SETTLE=2, XOR3 DUT at SETTLE=1.
// Results are predicted at start and graded when done pulses.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic [7:0] expected, expected1;
  logic       resp, resp1;
  logic [2:0] stim, stim1, ff, ff1;
  logic       busy, busy1, done, done1, pass, pass1;
  logic [7:0] tbl, tbl1;
  logic [3:0] err, err1;

  assign resp  = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
  assign resp1 = ^stim1;

  truth_table_sweep #(.WIDTH(3), .SETTLE(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_expected(expected), .i_resp(resp),
    .o_stim(stim), .o_busy(busy), .o_done(done),
    .o_table(tbl), .o_pass(pass), .o_err_count(err),
    .o_first_fail(ff)
  );

  truth_table_sweep #(.WIDTH(3), .SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1),
    .i_expected(expected1), .i_resp(resp1),
    .o_stim(stim1), .o_busy(busy1), .o_done(done1),
    .o_table(tbl1), .o_pass(pass1), .o_err_count(err1),
    .o_first_fail(ff1)
  );

  typedef struct packed {
    logic [7:0] tab;
    logic       pass;
    logic [3:0] err;
    logic [2:0] ff;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t e0, e1;
  int   total = 0;
  int   bad   = 0;
  int   ndone0 = 0;
  int   ndone1 = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] maj_tab();
    logic [7:0] t;
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v    = 3'(k);
      t[k] = ($countones(v) >= 2);
    end
    return t;
  endfunction

  function automatic logic [7:0] xor_tab();
    logic [7:0] t;
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v    = 3'(k);
      t[k] = ($countones(v) % 2) == 1;
    end
    return t;
  endfunction

  function automatic res_t model(input logic [7:0] tab, input logic [7:0] exp);
    res_t r;
    logic [7:0] d;
    d     = tab ^ exp;
    r.tab = tab;
    r.err = '0;
    r.ff  = '0;
    for (int k = 7; k >= 0; k--) begin
      if (d[k]) begin
        r.err = r.err + 4'd1;
        r.ff  = 3'(k);
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      ndone0++;
      if (q0.size() == 0) begin
        check("sb0_empty", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("table", 32'(tbl),  32'(e0.tab));
        check("pass",  32'(pass), 32'(e0.pass));
        check("err",   32'(err),  32'(e0.err));
        check("ff",    32'(ff),   32'(e0.ff));
      end
    end
    if (done1) begin
      ndone1++;
      if (q1.size() == 0) begin
        check("sb1_empty", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("table1", 32'(tbl1),  32'(e1.tab));
        check("pass1",  32'(pass1), 32'(e1.pass));
        check("err1",   32'(err1),  32'(e1.err));
        check("ff1",    32'(ff1),   32'(e1.ff));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [7:0] exp, input bit re5, input bit hold);
    expected = exp;
    start    = 1'b1;
    tick();
    start = 1'b0;
    q0.push_back(model(maj_tab(), exp));
    for (int j = 0; j < 16; j++) begin
      check("busy", 32'(busy), 32'd1);
      check("stim", 32'(stim), 32'(j / 2));
      if (re5 && j == 5) begin
        start    = 1'b1;
        expected = ~exp;
      end else if (re5 && j == 6) begin
        start = 1'b0;
      end
      if (hold && j == 15) start = 1'b1;
      tick();
    end
    check("done",     32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("stim_end", 32'(stim), 32'd0);
    if (!hold) begin
      tick();
      check("done_clr", 32'(done), 32'd0);
    end
  endtask

  task automatic sweep1(input logic [7:0] exp);
    expected1 = exp;
    start1    = 1'b1;
    tick();
    start1 = 1'b0;
    q1.push_back(model(xor_tab(), exp));
    for (int j = 0; j < 8; j++) begin
      check("busy1", 32'(busy1), 32'd1);
      check("stim1", 32'(stim1), 32'(j));
      tick();
    end
    check("done1",     32'(done1), 32'd1);
    check("busy1_end", 32'(busy1), 32'd0);
    tick();
    check("done1_clr", 32'(done1), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    start1    = 1'b1;
    expected  = 8'hFF;
    expected1 = 8'hFF;
    repeat (2) begin
      tick();
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
    end
    check("rst_stim",  32'(stim), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_table", 32'(tbl),  32'd0);
    check("rst_pass",  32'(pass), 32'd0);
    check("rst_err",   32'(err),  32'd0);
    check("rst_ff",    32'(ff),   32'd0);
    rst    = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    sweep(8'hE8, 1'b0, 1'b0);
    sweep(8'hC9, 1'b0, 1'b0);
    sweep(8'hE8, 1'b1, 1'b0);
    sweep(8'hC9, 1'b0, 1'b1);
    sweep(8'hE8, 1'b0, 1'b0);

    expected = 8'hE8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_stim",  32'(stim), 32'd0);
    check("abort_table", 32'(tbl),  32'd0);
    check("abort_err",   32'(err),  32'd0);
    repeat (12) begin
      tick();
      check("abort_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    sweep(8'hE8, 1'b0, 1'b0);

    sweep1(8'h96);
    sweep1(8'h97);

    repeat (2) tick();
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    check("ndone0",  32'(ndone0),    32'd6);
    check("ndone1",  32'(ndone1),    32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
